// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types for the nibble-serial add/sub sequencer.
// FSM encoding and the datapath slice width.
package nibble_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_rca4.sv
// 4-bit ripple-carry adder: the single shared datapath slice.
// Purely combinational; carry ripples bit 0 to bit 3.
module nibble_serial_addsub_ctrl_rca4
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic w_c;

  always_comb begin
    o_sum = '0;
    w_c   = i_cin;
    for (int k = 0; k < NIBBLE_W; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c      = (i_a[k] & i_b[k]) |
                 (w_c & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Sequencer sharing one 4-bit adder for W-bit add/sub,
// one nibble per cycle, LSB first, carry kept in a register.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_sub,
  input  logic [4*NIBBLES-1:0]    i_a,
  input  logic [4*NIBBLES-1:0]    i_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NIBBLES-1:0]    o_result,
  output logic                    o_carry_out,
  output logic                    o_overflow
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e r_state;
  state_e w_next;

  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_result;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic                r_cout;
  logic                r_ovf;

  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;

  assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  nibble_serial_addsub_ctrl_rca4 u_rca4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_accept = i_start && (r_state != RUN);
    w_last   = (r_idx == IW'(NIBBLES - 1));
    w_next   = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = w_accept ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract; carry-in of 1 completes -B.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= i_a;
      r_b      <= i_b ^ {W{i_sub}};
      r_carry  <= i_sub;
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_result[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) &&
                  (w_sum[NIBBLE_W-1] != r_a[W-1]);
      end
    end
  end

  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_result    = r_result;
  assign o_carry_out = r_cout;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Scoreboard bench: three widths (2/4/8 nibbles) on one clock,
// expected results queued at issue and checked on done.
module tb_nibble_serial_addsub_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st0 = 0, sb0 = 0, st1 = 0;
  logic        sb1 = 0, st2 = 0, sb2 = 0;
  logic [7:0]  a0 = 0, b0 = 0;
  logic [15:0] a1 = 0, b1 = 0;
  logic [31:0] a2 = 0, b2 = 0;
  logic        busy0, done0, co0, ov0;
  logic        busy1, done1, co1, ov1;
  logic        busy2, done2, co2, ov2;
  logic [7:0]  res0;
  logic [15:0] res1;
  logic [31:0] res2;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   n_chk  = 0;
  int   n_pass = 0;

  nibble_serial_addsub_ctrl #(.NIBBLES(2)) u_n2 (
    .i_clk(clk), .i_rst(rst), .i_start(st0),
    .i_sub(sb0), .i_a(a0), .i_b(b0),
    .o_busy(busy0), .o_done(done0),
    .o_result(res0), .o_carry_out(co0),
    .o_overflow(ov0)
  );

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) u_n4 (
    .i_clk(clk), .i_rst(rst), .i_start(st1),
    .i_sub(sb1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1),
    .o_result(res1), .o_carry_out(co1),
    .o_overflow(ov1)
  );

  nibble_serial_addsub_ctrl #(.NIBBLES(8)) u_n8 (
    .i_clk(clk), .i_rst(rst), .i_start(st2),
    .i_sub(sb2), .i_a(a2), .i_b(b2),
    .o_busy(busy2), .o_done(done2),
    .o_result(res2), .o_carry_out(co2),
    .o_overflow(ov2)
  );

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic exp_t model(int w,
                                 logic [31:0] a,
                                 logic [31:0] b,
                                 logic s);
    exp_t        e;
    logic [31:0] m;
    logic [31:0] bb;
    logic [32:0] sum;
    m   = (w == 32) ? 32'hFFFF_FFFF
                    : ((32'h1 << w) - 32'h1);
    bb  = (s ? ~b : b) & m;
    sum = {1'b0, a & m} + {1'b0, bb} + 33'(s);
    e.res = sum[31:0] & m;
    e.co  = sum[w];
    e.ov  = (a[w-1] == bb[w-1]) &&
            (e.res[w-1] != a[w-1]);
    return e;
  endfunction

  function automatic logic get_done(int k);
    case (k)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(int k);
    case (k)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_in(int k, logic [31:0] a,
                        logic [31:0] b, logic s,
                        logic st);
    case (k)
      0: begin
        a0 = a[7:0]; b0 = b[7:0]; sb0 = s; st0 = st;
      end
      1: begin
        a1 = a[15:0]; b1 = b[15:0]; sb1 = s; st1 = st;
      end
      default: begin
        a2 = a; b2 = b; sb2 = s; st2 = st;
      end
    endcase
  endtask

  // Drive at a negedge; inputs are scrambled after the accept edge.
  task automatic issue(int k, logic [31:0] a,
                       logic [31:0] b, logic s,
                       exp_t e);
    set_in(k, a, b, s, 1'b1);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    set_in(k, $urandom, $urandom, 1'($urandom), 1'b0);
  endtask

  task automatic wait_done(int k, output int nbusy);
    bit seen;
    seen  = 0;
    nbusy = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (get_done(k)) seen = 1;
      else begin
        if (get_busy(k)) nbusy++;
        @(negedge clk);
      end
    end
    if (!seen) check("done timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) check("n2 spurious done", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("n2 result", {24'h0, res0}, e0.res);
        check("n2 carry", {31'h0, co0}, {31'h0, e0.co});
        check("n2 ovf", {31'h0, ov0}, {31'h0, e0.ov});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) check("n4 spurious done", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("n4 result", {16'h0, res1}, e1.res);
        check("n4 carry", {31'h0, co1}, {31'h0, e1.co});
        check("n4 ovf", {31'h0, ov1}, {31'h0, e1.ov});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) check("n8 spurious done", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("n8 result", res2, e2.res);
        check("n8 carry", {31'h0, co2}, {31'h0, e2.co});
        check("n8 ovf", {31'h0, ov2}, {31'h0, e2.ov});
      end
    end
  end

  initial begin
    int          nb;
    logic [31:0] ra, rb;
    logic        rs;
    exp_t        x;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst busy", {31'h0, busy0}, 0);
    check("rst done", {31'h0, done0}, 0);
    check("rst result", {24'h0, res0}, 0);
    check("rst carry", {31'h0, co0}, 0);
    check("rst ovf", {31'h0, ov0}, 0);
    rst = 1'b0;
    @(negedge clk);

    x = '{res: 32'h83, co: 1'b0, ov: 1'b1};
    issue(0, 32'h3C, 32'h47, 1'b0, x);
    wait_done(0, nb);
    check("n2 busy cycles", nb, 2);

    x = '{res: 32'h00, co: 1'b1, ov: 1'b0};
    issue(0, 32'hFF, 32'h01, 1'b0, x);
    wait_done(0, nb);
    x = '{res: 32'hFE, co: 1'b1, ov: 1'b0};
    issue(0, 32'hFF, 32'h01, 1'b1, x);
    wait_done(0, nb);
    repeat (3) @(negedge clk);
    check("n2 hold idle", {24'h0, res0}, 32'hFE);
    check("n2 idle done", {31'h0, done0}, 0);

    x = '{res: 32'hFFFE, co: 1'b0, ov: 1'b0};
    issue(1, 32'h0005, 32'h0007, 1'b1, x);
    wait_done(1, nb);
    check("n4 busy cycles", nb, 4);
    x = '{res: 32'h7FFF, co: 1'b1, ov: 1'b1};
    issue(1, 32'h8000, 32'h0001, 1'b1, x);
    wait_done(1, nb);
    check("n4 b2b busy", nb, 4);

    // Start pulsed mid-RUN must be dropped.
    @(negedge clk);
    x = '{res: 32'h1335, co: 1'b0, ov: 1'b0};
    issue(1, 32'h1234, 32'h0101, 1'b0, x);
    set_in(1, 32'hAAAA, 32'h5555, 1'b1, 1'b1);
    @(negedge clk);
    set_in(1, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_done(1, nb);
    repeat (8) @(negedge clk);

    // Reset in the second RUN cycle.
    x = '{res: 32'h0, co: 1'b0, ov: 1'b0};
    issue(1, 32'h4321, 32'h1111, 1'b0, x);
    @(negedge clk);
    check("n4 mid busy", {31'h0, busy1}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid busy", {31'h0, busy1}, 0);
    check("rst mid done", {31'h0, done1}, 0);
    check("rst mid result", {16'h0, res1}, 0);
    check("rst mid carry", {31'h0, co1}, 0);
    rst = 1'b0;
    q1.delete();
    repeat (8) @(negedge clk);
    x = '{res: 32'h5432, co: 1'b0, ov: 1'b0};
    issue(1, 32'h4321, 32'h1111, 1'b0, x);
    wait_done(1, nb);
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        x  = model(8 << k, ra, rb, rs);
        issue(k, ra, rb, rs, x);
        wait_done(k, nb);
        check("rand busy cycles", nb, 2 << k);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("n2 sb empty", q0.size(), 0);
    check("n4 sb empty", q1.size(), 0);
    check("n8 sb empty", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
